divu_seq: RTL

Multi-cycle sequencer for the unsigned divide path of the pipelined MIPS-lite CPU. It accepts a `divu` issue from EX, runs a 32-step restoring division and writes the HI/LO registers. It serves `mfhi`/`mflo` reads and raises a pipeline stall while a read would see stale HI/LO. It sits beside the ALU in EX and is driven by the ALU control's `Divu` and `sel` decode.

---
 rtl/mips_lite_pkg.sv | 24 ++
 rtl/divu_seq_if.sv | 26 ++
 rtl/divu_step.sv | 30 +++
 rtl/divu_seq.sv | 106 ++++++++++
 4 files changed

// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: divider FSM states, HI/LO read-select codes
// and the funct codes the ALU control decodes into Divu/sel.
package mips_lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } divu_state_t;

    // Must track the ALU control's sel encoding for mfhi/mflo.
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_HI   = 2'b01;
    localparam logic [1:0] SEL_LO   = 2'b10;

    localparam logic [5:0] F_divu = 6'b011011;
    localparam logic [5:0] F_mfhi = 6'b010000;
    localparam logic [5:0] F_mflo = 6'b010010;

    function automatic logic sel_is_read(input logic [1:0] sel);
        return (sel == SEL_HI) || (sel == SEL_LO);
    endfunction

endpackage

// File: rtl/divu_seq_if.sv
// Issue/readback bundle between EX (ALU control) and the divide sequencer.
interface divu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [1:0]       sel;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;

    modport master (
        output start, dividend, divisor, sel,
        input  busy, stall, done, div0, hi, lo, result
    );

    modport slave (
        input  start, dividend, divisor, sel,
        output busy, stall, done, div0, hi, lo, result
    );
endinterface

// File: rtl/divu_step.sv
// One restoring-division step: shift {acc, q} left, subtract divisor if it fits.
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_shifted;
    logic             fits;

    // acc < divisor on entry, so the WIDTH+1-bit difference always fits in WIDTH bits.
    always_comb begin
        shifted   = {acc, q[WIDTH-1]};
        q_shifted = {q[WIDTH-2:0], 1'b0};
        fits      = (shifted >= {1'b0, divisor});
        diff      = shifted - {1'b0, divisor};
        if (fits) begin
            acc_next = diff[WIDTH-1:0];
            q_next   = q_shifted | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            acc_next = shifted[WIDTH-1:0];
            q_next   = q_shifted;
        end
    end
endmodule

// File: rtl/divu_seq.sv
// Multi-cycle unsigned divide sequencer writing HI/LO, with mfhi/mflo stall.
// Optional DIVU_EARLY_OUT_EN: dividend < divisor (divisor != 0) completes at accept.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start; HI/LO hold last result
// ST_RUN  | one restoring step per cycle, count down to 0
// ST_DONE | HI/LO just written, done pulse, back to IDLE
module divu_seq
    import mips_lite_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    divu_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    divu_state_t      state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             div0_r;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] result_c;

    divu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q),
        .divisor  (dvsr),
        .acc_next (acc_n),
        .q_next   (q_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            acc    <= '0;
            q      <= '0;
            dvsr   <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            div0_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        div0_r <= (bus.divisor == '0);
                        dvsr   <= bus.divisor;
                        acc    <= '0;
                        q      <= bus.dividend;
                        count  <= CW'(WIDTH - 1);
`ifdef DIVU_EARLY_OUT_EN
                        if ((bus.divisor != '0) && (bus.dividend < bus.divisor)) begin
                            hi_r  <= bus.dividend;
                            lo_r  <= '0;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
`else
                        state  <= ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    if (count == '0) begin
                        hi_r  <= acc_n;
                        lo_r  <= q_n;
                        state <= ST_DONE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // HI/LO are already valid in DONE, so only RUN or a same-cycle issue blocks a read.
    always_comb begin
        result_c = '0;
        if (bus.sel == SEL_HI)
            result_c = hi_r;
        else if (bus.sel == SEL_LO)
            result_c = lo_r;
    end

    assign bus.busy   = (state == ST_RUN);
    assign bus.done   = (state == ST_DONE);
    assign bus.div0   = div0_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;
    assign bus.result = result_c;
    assign bus.stall  = sel_is_read(bus.sel) &&
                        ((state == ST_RUN) || ((state == ST_IDLE) && bus.start));
endmodule
